// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_SUB  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SLA  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13;
    localparam logic [3:0] OP_SHLV = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/alu_pipe_if.sv
// Handshaked operand/result bus of alu_pipe.
//   master: drives operands/opcode and out_ready (register-file / writeback side)
//   slave : the ALU; returns in_ready, result and flags
interface alu_pipe_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             illegal;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative, illegal
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative, illegal
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, async active-low reset (abandons any operation)
//   start      : load operands (only while not busy)
//   a, b       : WIDTH-bit operands
//   done       : high during the last iteration cycle
//   product    : 2*WIDTH product, valid while done is high
// The product is taken from the adder output so the consumer can register
// it on the same edge that retires the final iteration.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mc;
    logic [WIDTH-1:0]   mp;
    logic [2*WIDTH-1:0] sum;

    assign sum     = acc + (mp[0] ? mc : '0);
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            mc   <= '0;
            mp   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            mc   <= {{WIDTH{1'b0}}, a};
            mp   <= b;
        end else if (busy) begin
            acc <= sum;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with registered result/flags and valid/ready on both sides.
//   clk, rst_n : clock, async active-low reset
//   io (slave) : in_valid/in_ready/a/b/op in, out_valid/out_ready/result and
//                carry/overflow/zero/negative/illegal out
// Single-cycle ops load the output register on the accept edge. MUL goes
// IDLE->BUSY for WIDTH cycles in alu_mul_iter and loads on its last step.
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  io
);
    localparam int M = WIDTH - 1;

    logic [0:0]       state;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, overflow_q, zero_q, negative_q, illegal_q;

    logic             in_ready;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    // Results of the single-cycle datapath
    logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, shl_w;
    logic             slt;
    logic [WIDTH-1:0] r_n;
    logic             c_n, v_n, z_n, ill_n;

    assign in_ready  = (state == ST_IDLE) && (!out_valid_q || io.out_ready);
    assign accept    = io.in_valid && in_ready;
    assign mul_start = accept && (io.op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (io.a),
        .b       (io.b),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign add_w = {1'b0, io.a} + {1'b0, io.b};
    assign sub_w = {1'b0, io.a} - {1'b0, io.b};
    assign inc_w = {1'b0, io.a} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w = {1'b0, io.a} - {{WIDTH{1'b0}}, 1'b1};
    // Bit WIDTH of the widened shift is the last bit pushed out of the word.
    assign shl_w = {1'b0, io.a} << io.b[SHW-1:0];
    // True signed compare; a wrapped difference sign would be wrong on overflow.
    assign slt   = $signed(io.a) < $signed(io.b);

    always_comb begin
        r_n   = '0;
        c_n   = 1'b0;
        v_n   = 1'b0;
        ill_n = 1'b0;
        case (io.op)
            OP_SUB: begin
                r_n = sub_w[M:0];
                c_n = ~sub_w[WIDTH];
                v_n = (io.a[M] ^ io.b[M]) & (sub_w[M] ^ io.a[M]);
            end
            OP_ADD: begin
                r_n = add_w[M:0];
                c_n = add_w[WIDTH];
                v_n = ~(io.a[M] ^ io.b[M]) & (add_w[M] ^ io.a[M]);
            end
            OP_OR:  r_n = io.a | io.b;
            OP_AND: r_n = io.a & io.b;
            OP_DEC: begin
                r_n = dec_w[M:0];
                c_n = ~dec_w[WIDTH];
                v_n = io.a[M] & ~dec_w[M];
            end
            OP_INC: begin
                r_n = inc_w[M:0];
                c_n = inc_w[WIDTH];
                v_n = ~io.a[M] & inc_w[M];
            end
            OP_NOT: r_n = ~io.a;
            OP_SLA: begin
                r_n = {io.a[M-1:0], 1'b0};
                c_n = io.a[M];
                v_n = io.a[M] ^ io.a[M-1];
            end
            OP_SRA: begin
                r_n = {io.a[M], io.a[M:1]};
                c_n = io.a[0];
            end
            OP_SLL: begin
                r_n = {io.a[M-1:0], 1'b0};
                c_n = io.a[M];
            end
            OP_SRL: begin
                r_n = {1'b0, io.a[M:1]};
                c_n = io.a[0];
            end
            OP_SLT:  r_n = {{(WIDTH-1){1'b0}}, slt};
            OP_XOR:  r_n = io.a ^ io.b;
            OP_SHLV: begin
                r_n = shl_w[M:0];
                c_n = shl_w[WIDTH];
            end
            OP_RSVD: ill_n = 1'b1;
            default: ;  // OP_MUL is handled by the iterative path
        endcase
        // Reserved opcode reports only illegal; every other flag stays low.
        z_n = ~ill_n & ~|r_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (mul_start) begin
            state <= ST_BUSY;
        end else if (state == ST_BUSY && mul_done) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept && !mul_start) begin
            out_valid_q <= 1'b1;
            result_q    <= r_n;
            carry_q     <= c_n;
            overflow_q  <= v_n;
            zero_q      <= z_n;
            negative_q  <= r_n[M];
            illegal_q   <= ill_n;
        end else if (state == ST_BUSY && mul_done) begin
            // out_valid was already clear when the MUL was accepted.
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[M:0];
            carry_q     <= 1'b0;
            overflow_q  <= |mul_prod[2*WIDTH-1:WIDTH];
            zero_q      <= ~|mul_prod[M:0];
            negative_q  <= mul_prod[M];
            illegal_q   <= 1'b0;
        end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.carry     = carry_q;
    assign io.overflow  = overflow_q;
    assign io.zero      = zero_q;
    assign io.negative  = negative_q;
    assign io.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op at a negedge once in_ready is seen, hold it across one edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("issue_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Negedges after the accept edge until out_valid, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 40);
    endtask

    task automatic check_op(input string tag, input logic [3:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] r, input logic c, input logic v,
                            input logic z, input logic n);
        int cyc;
        issue(op, a, b);
        wait_out(cyc);
        chk({tag, "_lat"}, cyc, (op == OP_MUL) ? 32'd17 : 32'd1);
        chk({tag, "_res"}, {16'd0, bus.result}, {16'd0, r});
        chk({tag, "_cvzn"}, {28'd0, bus.carry, bus.overflow, bus.zero, bus.negative},
            {28'd0, c, v, z, n});
        chk({tag, "_ill"}, {31'd0, bus.illegal}, 32'd0);
    endtask

    initial begin
        int cyc, busy, stale;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ov",  {31'd0, bus.out_valid}, 32'd0);
        chk("rst_res", {16'd0, bus.result}, 32'd0);
        chk("rst_flg", {27'd0, bus.carry, bus.overflow, bus.zero, bus.negative, bus.illegal}, 32'd0);
        chk("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;

        //           tag      op       a         b         result    c     v     z     n
        check_op("add_ov",  OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        check_op("add_c",   OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        check_op("sub_eq",  OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        check_op("sub_bor", OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        check_op("sub_ov",  OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        check_op("slt_1",   OP_SLT,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_op("slt_wr",  OP_SLT,  16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_op("slt_0",   OP_SLT,  16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check_op("or",      OP_OR,   16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_op("and",     OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_op("xor",     OP_XOR,  16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
        check_op("not",     OP_NOT,  16'h0000, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        check_op("dec_0",   OP_DEC,  16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        check_op("dec_ov",  OP_DEC,  16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        check_op("inc_c",   OP_INC,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        check_op("inc_ov",  OP_INC,  16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        check_op("sla",     OP_SLA,  16'h4000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        check_op("sll",     OP_SLL,  16'hC001, 16'h0000, 16'h8002, 1'b1, 1'b0, 1'b0, 1'b1);
        check_op("sra",     OP_SRA,  16'h8001, 16'h0000, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b1);
        check_op("srl",     OP_SRL,  16'h8001, 16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_op("shlv_1",  OP_SHLV, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        check_op("shlv_0",  OP_SHLV, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1);
        check_op("shlv_15", OP_SHLV, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
        check_op("mul_3x5", OP_MUL,  16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        check_op("mul_ff",  OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

        // MUL latency and in_ready profile
        issue(OP_MUL, 16'h0100, 16'h0100);
        busy = 0;
        cyc  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.in_ready && !bus.out_valid) busy++;
        end while (!bus.out_valid && cyc < 40);
        chk("mul_lat",  cyc, 32'd17);
        chk("mul_busy", busy, 32'd16);
        chk("mul_res",  {16'd0, bus.result}, 32'd0);
        chk("mul_vz",   {30'd0, bus.overflow, bus.zero}, 32'd3);

        // Reserved opcode, then confirm illegal drops on the next op
        issue(OP_RSVD, 16'h1234, 16'h5678);
        wait_out(cyc);
        chk("ill_lat", cyc, 32'd1);
        chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
        chk("ill_res", {16'd0, bus.result}, 32'd0);
        check_op("post_ill", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure: ADD held, INC waits, then drain+accept in one cycle
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(OP_ADD, 16'h0001, 16'h0002);
        bus.in_valid = 1'b1;
        bus.op = OP_INC;
        bus.a  = 16'h0010;
        bus.b  = 16'h0000;
        @(negedge clk);
        chk("bp_ov0",  {31'd0, bus.out_valid}, 32'd1);
        chk("bp_res0", {16'd0, bus.result}, 32'h0003);
        chk("bp_rdy0", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_res1", {16'd0, bus.result}, 32'h0003);
        chk("bp_rdy1", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        #1 chk("bp_rdy2", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_ov2",  {31'd0, bus.out_valid}, 32'd1);
        chk("bp_res2", {16'd0, bus.result}, 32'h0011);

        // Reset in the middle of a MUL
        issue(OP_MUL, 16'hFFFF, 16'hFFFF);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_ov",  {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_res", {16'd0, bus.result}, 32'd0);
        chk("mrst_flg", {27'd0, bus.carry, bus.overflow, bus.zero, bus.negative, bus.illegal}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", {31'd0, bus.in_ready}, 32'd1);
        stale = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("mrst_stale", stale, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 16-bit combinational ALU.
- Width is generic, and all outputs (result and flags) are registered.
- Adds an iterative multi-cycle unsigned multiply, XOR, variable shift, and separate carry/overflow/negative flags.
- Sits between the operand register file and the writeback stage; valid/ready on both sides.

Parameters:
- WIDTH, 16: operand/result width; must be at least 4.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from B[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  4  opcode (encoding below)
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  registered result
- carry  output  1  carry / no-borrow / shifted-out bit
- overflow  output  1  signed overflow (MUL: unsigned overflow)
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]
- illegal  output  1  reserved opcode was issued

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, named clk and rst_n. While rst_n is 0, every output register is 0 (out_valid, result, all flags, illegal) and the FSM is in IDLE. Reset mid-multiply abandons the operation; no result is produced.
- Opcode encoding: 0 SUB, 1 ADD, 2 OR, 3 AND, 4 DEC, 5 INC, 6 NOT A, 7 SLA, 8 SRA, 9 SLL, 10 SRL, 11 SLT (signed), 12 MUL, 13 XOR, 14 SHLV (A << B[SHW-1:0]), 15 reserved.
- Opcode 15: result 0, illegal=1, other flags 0, latency 1.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A same-cycle drain plus accept is allowed.
  - The output holds stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result is loaded in the same cycle.
- Latency:
  - Non-MUL ops: the result is registered on the accept edge; out_valid=1 the next cycle. Back-to-back throughput is 1 op/cycle.
  - MUL: IDLE -> BUSY, with a shift-add iteration counter of WIDTH cycles. Then BUSY -> IDLE with out_valid=1, exactly WIDTH+1 cycles after accept. in_ready=0 throughout BUSY.
- FSM states: IDLE, BUSY only. The counter is cleared on MUL accept and advances each BUSY cycle.
- Flags:
  - ADD/INC: carry = carry-out; overflow = signed overflow.
  - SUB/DEC: carry = no-borrow (A>=B unsigned); overflow = signed overflow.
  - SLA/SLL: carry = a[WIDTH-1]. Overflow for SLA is a[WIDTH-1]^a[WIDTH-2]; for SLL it is 0.
  - SRA/SRL: carry = a[0]; overflow 0.
  - SHLV: carry = last bit shifted out (0 if amount is 0); overflow 0.
  - MUL: result = low WIDTH bits; overflow = high half nonzero; carry 0.
  - Logic ops, NOT, SLT: carry=0, overflow=0.
  - zero and negative are always derived from the final result.
- SLT: result 1 if signed A<B, else 0; it must not be derived from a wrapped subtraction alone.

Decomposition:
- Shared package alu_pkg holds the opcode localparams (OP_SUB..OP_RSVD) and the FSM state encodings.
- One sub-module, alu_mul_iter: the iterative shift-add multiplier with start/done, width WIDTH, producing a 2*WIDTH product.
- The combinational ops stay inline in alu_pipe.

Test Plan:
- WIDTH=16, ADD a=16'h7FFF b=16'h0001 -> next cycle result 16'h8000, overflow=1, carry=0, negative=1, zero=0.
- SUB a=16'h0005 b=16'h0005 -> result 0, zero=1, carry=1, overflow=0. SLT a=16'hFFFF b=16'h0001 -> result 1.
- MUL a=16'h0100 b=16'h0100 -> in_ready low 16 cycles, out_valid on cycle 17, result 0, overflow=1, zero=1. MUL 16'h0003 x 16'h0005 -> 16'h000F, overflow=0.
- Backpressure: issue ADD then INC with out_ready=0 -> first result held stable and in_ready=0. Raising out_ready drains ADD and accepts INC in the same cycle.
- Opcode 15 -> illegal=1, result 0. SHLV a=16'h8001 b=16'h0001 -> result 16'h0002, carry=1.
- Assert rst_n low 5 cycles into a MUL -> all outputs 0 immediately. After release, in_ready=1 and no stale out_valid appears.
